// File: rtl/enc_prio_rr_pkg.sv
// rtl/enc_prio_rr_pkg.sv - shared types and helpers for the priority/round-robin encoder
// Purpose: search-mode enum, index-width helper and the upper bound on request count.
// Ports: none (package enc_pkg).
package enc_pkg;

  typedef enum logic {
    ENC_FIXED = 1'b0,
    ENC_RR    = 1'b1
  } enc_mode_e;

  localparam int ENC_MAX_N = 64;

  // Width of an index into n requests; never below 1 so buses stay legal.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/enc_prio_rr_if.sv
// rtl/enc_prio_rr_if.sv - request/result handshake bundle for enc_prio_rr
// Purpose: groups the input handshake (in_valid/in_ready/req) and the result
//          handshake (out_valid/out_ready/out_idx/out_none/out_err).
// Modports: master = request source and consumer; slave = encoder.
interface enc_prio_rr_if #(
  parameter int N = 8
);
  import enc_pkg::*;

  localparam int W = idx_w(N);

  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] req;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_idx;
  logic         out_none;
  logic         out_err;

  modport master (
    output in_valid, req, out_ready,
    input  in_ready, out_valid, out_idx, out_none, out_err
  );

  modport slave (
    input  in_valid, req, out_ready,
    output in_ready, out_valid, out_idx, out_none, out_err
  );

endinterface

// File: rtl/enc_prio_rr_pick.sv
// rtl/enc_prio_rr_pick.sv - combinational first-set search starting at a pointer
// Purpose: rotate req so ptr_i lands at bit 0, find the lowest set bit, then map
//          the offset back with a modulo-N subtract (N need not be a power of two).
// Ports: req_i[N] request vector, ptr_i[W] search start (< N),
//        found_o any bit set, idx_o[W] winning index (equals ptr_i when !found_o).
module enc_rr_pick
  import enc_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = idx_w(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [N-1:0] rot;
  int           off;
  int           sum;

  always_comb begin
    rot = '0;
    off = 0;
    sum = 0;
    for (int i = 0; i < N; i++) begin
      // Source bit is (i + ptr) mod N; a single subtract suffices since ptr < N.
      if (i + int'(ptr_i) >= N) begin
        rot[i] = req_i[i + int'(ptr_i) - N];
      end else begin
        rot[i] = req_i[i + int'(ptr_i)];
      end
    end
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        off = i;
      end
    end
    sum = off + int'(ptr_i);
    if (sum >= N) begin
      sum = sum - N;
    end
  end

  assign found_o = |req_i;
  assign idx_o   = W'(sum);

endmodule

// File: rtl/enc_prio_rr.sv
// rtl/enc_prio_rr.sv - N-to-log2(N) encoder, fixed-priority or round-robin, registered result
// Purpose: accepts one request vector per in_valid/in_ready transfer and presents
//          the winning index one cycle later on a held out_valid/out_ready result.
// Ports: clk, rst_n (async assert, active low), bus (enc_prio_rr_if.slave).
// Macro: ENC_ONEHOT_CHECK_EN enables the multi-hot flag on out_err; otherwise out_err is 0.
module enc_prio_rr
  import enc_pkg::*;
#(
  parameter int N       = 8,
  parameter int RR_MODE = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  enc_prio_rr_if.slave       bus
);

  localparam int            W        = idx_w(N);
  localparam enc_mode_e     MODE     = (RR_MODE != 0) ? ENC_RR : ENC_FIXED;
  localparam logic [W-1:0]  LAST_IDX = W'(N - 1);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_idx_q,   out_idx_d;
  logic         out_none_q,  out_none_d;
  logic [W-1:0] ptr_q,       ptr_d;

  logic         accept;
  logic         pop;
  logic         pick_found;
  logic [W-1:0] pick_ptr;
  logic [W-1:0] pick_idx;

  // Ready depends only on the output register, so there is no req/in_valid loop.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;
  assign pop          = out_valid_q && bus.out_ready;

  // Fixed priority is the same search with the start pinned at bit 0.
  assign pick_ptr = (MODE == ENC_RR) ? ptr_q : '0;

  enc_rr_pick #(.N(N)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (pick_ptr),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_none_d  = out_none_q;
    ptr_d       = ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_none_d  = !pick_found;
      out_idx_d   = pick_found ? pick_idx : '0;
      // An empty request is still a transfer but must not move the pointer.
      if (MODE == ENC_RR && pick_found) begin
        ptr_d = (pick_idx == LAST_IDX) ? '0 : pick_idx + W'(1);
      end
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_none_q  <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_none_q  <= out_none_d;
      ptr_q       <= ptr_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_idx   = out_idx_q;
  assign bus.out_none  = out_none_q;

`ifdef ENC_ONEHOT_CHECK_EN
  logic out_err_q, out_err_d;

  always_comb begin
    out_err_d = out_err_q;
    if (accept) begin
      out_err_d = ($countones(bus.req) > 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_err_q <= 1'b0;
    end else begin
      out_err_q <= out_err_d;
    end
  end

  assign bus.out_err = out_err_q;
`else
  assign bus.out_err = 1'b0;
`endif

endmodule

// File: tb/tb_enc_prio_rr.sv
// tb/tb_enc_prio_rr.sv - scoreboard bench for enc_prio_rr (fixed N=8, RR N=8, RR N=6)
module tb_enc_prio_rr;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] req;
  logic       out_ready;

  enc_prio_rr_if #(.N(8)) if_fix ();
  enc_prio_rr_if #(.N(8)) if_rr8 ();
  enc_prio_rr_if #(.N(6)) if_rr6 ();

  assign if_fix.in_valid  = in_valid;
  assign if_fix.req       = req;
  assign if_fix.out_ready = out_ready;
  assign if_rr8.in_valid  = in_valid;
  assign if_rr8.req       = req;
  assign if_rr8.out_ready = out_ready;
  assign if_rr6.in_valid  = in_valid;
  assign if_rr6.req       = req[5:0];
  assign if_rr6.out_ready = out_ready;

  enc_prio_rr #(.N(8), .RR_MODE(0)) u_fix (.clk(clk), .rst_n(rst_n), .bus(if_fix.slave));
  enc_prio_rr #(.N(8), .RR_MODE(1)) u_rr8 (.clk(clk), .rst_n(rst_n), .bus(if_rr8.slave));
  enc_prio_rr #(.N(6), .RR_MODE(1)) u_rr6 (.clk(clk), .rst_n(rst_n), .bus(if_rr6.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int idx_fix;
    int idx_rr8;
    int idx_rr6;
    bit none8;
    bit none6;
    bit err8;
    bit err6;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mvalid = 0;
  bit   cur_valid = 0;
  int   mptr8 = 0;
  int   mptr6 = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference rule: walk n positions upward from start, wrapping mod n; first set bit wins.
  function automatic int pick(input logic [7:0] r, input int n, input int start, output bit found);
    int win;
    found = 0;
    win   = 0;
    for (int k = 0; k < n; k++) begin
      if (!found && r[(start + k) % n]) begin
        found = 1;
        win   = (start + k) % n;
      end
    end
    return win;
  endfunction

  function automatic int ones(input logic [7:0] r, input int n);
    int c;
    c = 0;
    for (int k = 0; k < n; k++) c += int'(r[k]);
    return c;
  endfunction

  // One clock of stimulus; the model decides accept/pop from its own valid state.
  task automatic cyc(input bit v, input logic [7:0] r, input bit ordy);
    bit   ff, f8, f6;
    int   wf, w8, w6;
    exp_t e;
    @(posedge clk);
    #1;
    cur_valid = mvalid;
    in_valid  = v;
    req       = r;
    out_ready = ordy;
    if (v && (!mvalid || ordy)) begin
      wf = pick(r, 8, 0, ff);
      w8 = pick(r, 8, mptr8, f8);
      w6 = pick(r, 6, mptr6, f6);
      e.idx_fix = ff ? wf : 0;
      e.idx_rr8 = f8 ? w8 : 0;
      e.idx_rr6 = f6 ? w6 : 0;
      e.none8   = !f8;
      e.none6   = !f6;
`ifdef ENC_ONEHOT_CHECK_EN
      e.err8 = (ones(r, 8) > 1);
      e.err6 = (ones(r, 6) > 1);
`else
      e.err8 = 0;
      e.err6 = 0;
`endif
      if (f8) mptr8 = (w8 + 1) % 8;
      if (f6) mptr6 = (w6 + 1) % 6;
      sb_q.push_back(e);
      mvalid = 1;
    end else if (ordy) begin
      mvalid = 0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    chk("rst.fix.out_valid", if_fix.out_valid, 0);
    chk("rst.rr8.out_valid", if_rr8.out_valid, 0);
    chk("rst.rr8.out_idx",   if_rr8.out_idx,   0);
    chk("rst.rr8.out_none",  if_rr8.out_none,  0);
    chk("rst.rr6.out_valid", if_rr6.out_valid, 0);
    chk("rst.rr8.out_err",   if_rr8.out_err,   0);
    sb_q.delete();
    mvalid    = 0;
    cur_valid = 0;
    mptr8     = 0;
    mptr6     = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: compares every presented result against the queue head; pops on transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("fix.out_valid", if_fix.out_valid, cur_valid);
      chk("rr8.out_valid", if_rr8.out_valid, cur_valid);
      chk("rr6.out_valid", if_rr6.out_valid, cur_valid);
      chk("fix.in_ready",  if_fix.in_ready,  !cur_valid || out_ready);
      chk("rr8.in_ready",  if_rr8.in_ready,  !cur_valid || out_ready);
      chk("rr6.in_ready",  if_rr6.in_ready,  !cur_valid || out_ready);
      if (if_fix.out_valid) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got out_valid=1 expected no pending result at %0t", $time);
        end else begin
          chk("fix.out_idx",  if_fix.out_idx,  sb_q[0].idx_fix);
          chk("fix.out_none", if_fix.out_none, sb_q[0].none8);
          chk("fix.out_err",  if_fix.out_err,  sb_q[0].err8);
          chk("rr8.out_idx",  if_rr8.out_idx,  sb_q[0].idx_rr8);
          chk("rr8.out_none", if_rr8.out_none, sb_q[0].none8);
          chk("rr8.out_err",  if_rr8.out_err,  sb_q[0].err8);
          chk("rr6.out_idx",  if_rr6.out_idx,  sb_q[0].idx_rr6);
          chk("rr6.out_none", if_rr6.out_none, sb_q[0].none6);
          chk("rr6.out_err",  if_rr6.out_err,  sb_q[0].err6);
          if (out_ready) void'(sb_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [7:0] r;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    req       = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Mixed-bit request, lowest index wins.
    cyc(1, 8'b0010_1100, 1);
    cyc(0, 8'h00, 1);

    // Held request cycles the round-robin pointer.
    do_reset();
    repeat (4) cyc(1, 8'b1000_0101, 1);
    cyc(0, 8'h00, 1);

    // Empty request produces a transfer and leaves the pointer alone.
    do_reset();
    cyc(1, 8'h04, 1);
    cyc(1, 8'h00, 1);
    cyc(1, 8'h03, 1);
    cyc(0, 8'h00, 1);

    // Backpressure hold with changing req, then pop+accept in one cycle.
    do_reset();
    cyc(1, 8'h20, 1);
    cyc(1, 8'h01, 0);
    cyc(1, 8'h80, 0);
    cyc(1, 8'h02, 0);
    cyc(1, 8'h03, 1);
    cyc(0, 8'h00, 1);

    // N=6 wrap: bit 4 moves ptr to 5, then 6'b10_0001 wins at 5 and wraps to 0.
    do_reset();
    cyc(1, 8'h10, 1);
    cyc(1, 8'h21, 1);
    cyc(1, 8'h21, 1);
    cyc(0, 8'h00, 1);

    // Reset while a result is held with ptr=4.
    do_reset();
    cyc(1, 8'h08, 0);
    cyc(0, 8'h00, 0);
    do_reset();
    cyc(1, 8'hFF, 1);
    cyc(0, 8'h00, 1);

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       r = 8'h00;
        1:       r = 8'h01 << $urandom_range(0, 7);
        default: r = 8'($urandom);
      endcase
      cyc($urandom_range(0, 3) != 0, r, $urandom_range(0, 2) != 0);
    end

    repeat (3) cyc(0, 8'h00, 1);
    @(posedge clk);
    #1;
    chk("sb_drain", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
